// File: rtl/mux_cfg_loader.sv
// Configuration-chain loader: accepts bitstream words over valid/ready and
// shifts them MSB-first into the routing-mux config flip-flop chain.
module mux_cfg_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int WC_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0]  LAST_WBIT = WC_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  state_t             state, state_nx;
  logic [WORD_W-1:0]  shreg, shreg_nx;
  logic [WC_W-1:0]    wcnt, wcnt_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               done_r, done_nx;
  logic               err_r, err_nx;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state  <= IDLE;
      shreg  <= '0;
      wcnt   <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      wcnt   <= wcnt_nx;
      cnt    <= cnt_nx;
      done_r <= done_nx;
      err_r  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    wcnt_nx  = wcnt;
    cnt_nx   = cnt;
    done_nx  = done_r;
    err_nx   = err_r;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          cnt_nx   = '0;
          done_nx  = 1'b0;
          err_nx   = 1'b0;
          state_nx = WAIT_WORD;
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT_WORD: begin
        if (start) err_nx = 1'b1;
        if (abort) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (cfg_valid) begin
          shreg_nx = cfg_data;
          wcnt_nx  = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (start) err_nx = 1'b1;
        if (abort) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          shreg_nx = shreg << 1;
          wcnt_nx  = wcnt + 1'b1;
          if (cnt != LAST_BIT) cnt_nx = cnt + 1'b1;
          // done is raised on the final shift edge so it is visible while in DONE
          if (cnt + 1'b1 == LAST_BIT) begin
            done_nx  = 1'b1;
            state_nx = DONE;
          end else if (wcnt + 1'b1 == LAST_WBIT) begin
            state_nx = WAIT_WORD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cfg_ready = (state == WAIT_WORD);
  assign busy      = (state == WAIT_WORD) || (state == SHIFT);
  assign shift_en  = (state == SHIFT);
  assign ccff_head = shift_en && shreg[WORD_W-1];
  assign done      = done_r;
  assign error     = err_r;
  assign bit_count = cnt;

endmodule

// File: tb/tb_mux_cfg_loader.sv
// Directed bench for mux_cfg_loader: three instances (chain 6/16/1024) share
// stimulus; a bit queue predicts the serial stream of the selected instance.
module tb_mux_cfg_loader;

  logic       prog_clk = 1'b0;
  logic       pReset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = '0;

  always #5 prog_clk = ~prog_clk;

  logic r0, h0, s0, b0, d0, e0; logic [2:0]  bc0;
  logic r1, h1, s1, b1, d1, e1; logic [4:0]  bc1;
  logic r2, h2, s2, b2, d2, e2; logic [10:0] bc2;

  mux_cfg_loader #(.CHAIN_LEN(6), .WORD_W(8)) dut6 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(r0), .ccff_head(h0),
    .shift_en(s0), .busy(b0), .done(d0), .error(e0), .bit_count(bc0));

  mux_cfg_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(r1), .ccff_head(h1),
    .shift_en(s1), .busy(b1), .done(d1), .error(e1), .bit_count(bc1));

  mux_cfg_loader #(.CHAIN_LEN(1024), .WORD_W(8)) dut1k (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(r2), .ccff_head(h2),
    .shift_en(s2), .busy(b2), .done(d2), .error(e2), .bit_count(bc2));

  int sel = 0;
  int lens [3] = '{6, 16, 1024};
  logic t_ready, t_head, t_shift, t_busy, t_done, t_err;
  logic [10:0] t_cnt;

  always_comb begin
    case (sel)
      0:       begin t_ready = r0; t_head = h0; t_shift = s0; t_busy = b0; t_done = d0; t_err = e0; t_cnt = 11'(bc0); end
      1:       begin t_ready = r1; t_head = h1; t_shift = s1; t_busy = b1; t_done = d1; t_err = e1; t_cnt = 11'(bc1); end
      default: begin t_ready = r2; t_head = h2; t_shift = s2; t_busy = b2; t_done = d2; t_err = e2; t_cnt = bc2; end
    endcase
  end

  int vectors = 0;
  int miscompares = 0;
  bit q[$];
  int pushed, shifts, accepts, cycle, first_acc, last_shift_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: detect handshake before the edge, check serial output after it.
  task automatic cyc();
    logic       acc;
    logic [7:0] d;
    acc = cfg_valid && t_ready;
    d   = cfg_data;
    @(posedge prog_clk); #1;
    cycle++;
    if (acc) begin
      accepts++;
      if (accepts == 1) first_acc = cycle;
      for (int k = 7; k >= 0; k--)
        if (pushed < lens[sel]) begin
          q.push_back(d[k]);
          pushed++;
        end
    end
    if (t_shift) begin
      shifts++;
      last_shift_s = cycle;
      check("shift_has_word_bit", 32'(q.size() > 0), 1);
      if (q.size() > 0) check("ccff_head", 32'(t_head), 32'(q.pop_front()));
    end
  endtask

  task automatic clear_model();
    q.delete();
    pushed = 0; shifts = 0; accepts = 0; first_acc = 0; last_shift_s = 0;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    pReset_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    @(negedge prog_clk);
    pReset_n = 1'b1;
    clear_model();
    @(posedge prog_clk); #1;
  endtask

  task automatic pulse_start();
    clear_model();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int a0 = accepts;
    int n  = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    while (accepts == a0 && n < 64) begin cyc(); n++; end
    cfg_valid = 1'b0;
    check("word_accepted", 32'(accepts - a0), 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!t_ready && n < 64) begin cyc(); n++; end
    check("ready_timeout", 32'(t_ready), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (t_busy && n < 3000) begin cyc(); n++; end
    check("busy_timeout", 32'(t_busy), 0);
  endtask

  initial begin
    int a;
    int n;
    cycle = 0;
    clear_model();

    // Short chain: one word, two trailing bits discarded
    do_reset(0);
    check("rst_ready", 32'(t_ready), 0);
    check("rst_shift", 32'(t_shift), 0);
    check("rst_head",  32'(t_head), 0);
    check("rst_busy",  32'(t_busy), 0);
    check("rst_done",  32'(t_done), 0);
    check("rst_error", 32'(t_err), 0);
    check("rst_count", 32'(t_cnt), 0);
    pulse_start();
    check("t1_ready_after_start", 32'(t_ready), 1);
    check("t1_busy_after_start",  32'(t_busy), 1);
    send(8'hA4);
    wait_idle();
    check("t1_done",   32'(t_done), 1);
    check("t1_count",  32'(t_cnt), 6);
    check("t1_shifts", 32'(shifts), 6);
    check("t1_ready",  32'(t_ready), 0);
    check("t1_queue",  32'(q.size()), 0);
    cyc();
    check("t1_done_held",  32'(t_done), 1);
    check("t1_ready_idle", 32'(t_ready), 0);

    // Two words with a stall gap
    do_reset(1);
    pulse_start();
    send(8'h5A);
    wait_ready();
    check("t2_count_word0", 32'(t_cnt), 8);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t2_gap_shift", 32'(t_shift), 0);
    end
    send(8'hC3);
    wait_idle();
    check("t2_done",         32'(t_done), 1);
    check("t2_done_latency", 32'(cycle - last_shift_s), 1);
    check("t2_count",        32'(t_cnt), 16);
    check("t2_shifts",       32'(shifts), 16);
    check("t2_error",        32'(t_err), 0);

    // start while shifting: flagged but load unaffected
    do_reset(1);
    pulse_start();
    send(8'h5A);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("t3_error_set",  32'(t_err), 1);
    check("t3_still_busy", 32'(t_busy), 1);
    wait_ready();
    send(8'hC3);
    wait_idle();
    check("t3_done",   32'(t_done), 1);
    check("t3_error",  32'(t_err), 1);
    check("t3_count",  32'(t_cnt), 16);
    check("t3_shifts", 32'(shifts), 16);

    // Abort after three shifted bits
    do_reset(1);
    pulse_start();
    send(8'hFF);
    n = 0;
    while (t_cnt != 11'd3 && n < 20) begin cyc(); n++; end
    check("t4_count_pre", 32'(t_cnt), 3);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    q.delete();
    check("t4_shift", 32'(t_shift), 0);
    check("t4_busy",  32'(t_busy), 0);
    check("t4_ready", 32'(t_ready), 0);
    check("t4_error", 32'(t_err), 1);
    check("t4_done",  32'(t_done), 0);
    check("t4_count", 32'(t_cnt), 3);
    pulse_start();
    check("t4_error_cleared", 32'(t_err), 0);
    check("t4_count_cleared", 32'(t_cnt), 0);
    check("t4_ready_again",   32'(t_ready), 1);

    // Asynchronous reset mid-shift
    do_reset(1);
    pulse_start();
    send(8'hFF);
    cyc();
    cyc();
    pReset_n = 1'b0;
    #1;
    check("t5_shift", 32'(t_shift), 0);
    check("t5_head",  32'(t_head), 0);
    check("t5_busy",  32'(t_busy), 0);
    check("t5_ready", 32'(t_ready), 0);
    check("t5_count", 32'(t_cnt), 0);
    check("t5_error", 32'(t_err), 0);
    check("t5_done",  32'(t_done), 0);
    pReset_n = 1'b1;
    clear_model();
    cfg_data  = 8'hFF;
    cfg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t5_no_ready", 32'(t_ready), 0);
      check("t5_no_shift", 32'(t_shift), 0);
    end
    cfg_valid = 1'b0;
    check("t5_no_accept", 32'(accepts), 0);

    // Full 1024-bit chain with cfg_valid held high
    do_reset(2);
    pulse_start();
    cfg_data  = 8'($urandom);
    cfg_valid = 1'b1;
    a = accepts;
    n = 0;
    while (t_busy && n < 3000) begin
      cyc();
      n++;
      if (accepts != a) begin
        a = accepts;
        cfg_data = 8'($urandom);
      end
    end
    cfg_valid = 1'b0;
    check("t6_busy_timeout", 32'(t_busy), 0);
    check("t6_accepts", 32'(accepts), 128);
    check("t6_shifts",  32'(shifts), 1024);
    check("t6_count",   32'(t_cnt), 1024);
    check("t6_done",    32'(t_done), 1);
    check("t6_span",    32'(last_shift_s + 1 - first_acc + 1), 1152);
    check("t6_queue",   32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
